module_instruction_fetch: RTL and testbench
===========================================

Name: module_instruction_fetch

Overview:
Fetch stage directly downstream of the program counter. Accepts one PC address at a time, issues a request to instruction memory over a request/grant plus response-valid handshake, and holds the returned word for decode under a valid/ready handshake. Supports flush/redirect with in-flight response discard, and flags misaligned PCs. One outstanding memory transaction maximum.

Parameters:
XLEN, 32, address/data width
NOP_INSTR, 32'h00000013, value driven on instr when no valid fetched word is held (addi x0,x0,0)

Ports:
clock  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high; clears all state
pc_addr  input  XLEN  address from program counter
pc_valid  input  1  pc_addr is valid this cycle
pc_ready  output  1  fetch accepts pc_addr this cycle (transfer = pc_valid & pc_ready)
flush  input  1  kill current fetch and held instruction
imem_req  output  1  memory request
imem_addr  output  XLEN  request address
imem_gnt  input  1  memory accepted request this cycle
imem_rvalid  input  1  response data valid
imem_rdata  input  XLEN  response data
instr_valid  output  1  instr/instr_addr valid to decode
instr  output  XLEN  fetched instruction
instr_addr  output  XLEN  PC of instr
instr_ready  input  1  decode consumes (transfer = instr_valid & instr_ready)
misaligned  output  1  held entry is a misaligned-PC fault (qualified by instr_valid)

Behaviour:
- Reset (async): state IDLE; imem_req=0, imem_addr=0, instr_valid=0, instr=NOP_INSTR, instr_addr=0, misaligned=0, pc_ready=1 after release.
- States: IDLE, REQ, WAIT, HOLD, DROP.
- IDLE: pc_ready=1 (0 if flush). On transfer: latch pc_addr. If pc_addr[1:0]==0, go REQ; else go HOLD with misaligned=1, instr=NOP_INSTR, and no memory access.
- REQ: imem_req=1, imem_addr=latched address, held stable until imem_gnt. On imem_gnt, go WAIT.
- WAIT: imem_req=0. On imem_rvalid, capture imem_rdata into instr, go HOLD with misaligned=0. Response arrives no earlier than the cycle after grant; rvalid outside WAIT/DROP is ignored.
- HOLD: instr_valid=1; instr/instr_addr/misaligned stable until consumed. pc_ready = instr_ready & ~flush. On instr_ready:
  - pc_valid with aligned address: go REQ (back-to-back, no IDLE bubble).
  - pc_valid with misaligned address: stay HOLD with a new fault entry.
  - no pc_valid: go IDLE, instr returns to NOP_INSTR.
- Minimum latency: PC transfer in cycle N, req in N+1 (gnt same cycle), rvalid in N+2, instr_valid in N+3.
- Flush has priority over every other event:
  - REQ & ~gnt: drop request, go IDLE.
  - REQ & gnt: go DROP.
  - WAIT & ~rvalid: go DROP.
  - WAIT & rvalid: discard data, go IDLE.
  - HOLD: go IDLE, instr_valid=0 next cycle.
  - pc_ready=0 during any flush cycle.
- DROP: pc_ready=0, imem_req=0. On imem_rvalid, discard data and go IDLE. The stage never emits a stale word after flush.
- imem_req is deasserted only on grant or flush.
- Reset mid-transaction returns to IDLE immediately. The memory side is reset by the same signal.

Decomposition:
- Shared package: fetch state enumeration (5 states, 3-bit encoding), NOP_INSTR constant, XLEN.
- No sub-module. FSM plus output registers is one block.

Test Plan:
- Reset, pc_addr=0x00000000 valid, gnt same cycle, rvalid next cycle with rdata=0x00500093 -> instr_valid in cycle 3 after transfer, instr=0x00500093, instr_addr=0.
- Stream 0x0, 0x4, 0x8 with instr_ready=1 and immediate gnt/rvalid -> one instruction every 3 cycles, no IDLE cycles, addresses in order.
- pc_addr=0x00000006 -> no imem_req, instr_valid=1, misaligned=1, instr=0x00000013, instr_addr=0x6.
- Grant fetch of 0x10, flush in WAIT, rvalid 2 cycles later with 0xDEADBEEF -> word discarded, instr_valid stays 0, pc_ready=0 until DROP exits, then next PC 0x40 fetched normally.
- Hold instr_ready=0 for 5 cycles with gnt delayed 3 cycles -> imem_addr stable while imem_req=1; instr/instr_addr stable while instr_valid=1 and not consumed.
- Assert reset during WAIT -> outputs return to reset values asynchronously; after release, a late rvalid is ignored.

Source files
------------

// File: rtl/module_instruction_fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package module_instruction_fetch_pkg;

    localparam int unsigned XLEN = 32;
    localparam logic [XLEN-1:0] NOP_INSTR = 32'h00000013;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_REQ  = 3'd1,
        ST_WAIT = 3'd2,
        ST_HOLD = 3'd3,
        ST_DROP = 3'd4
    } fetch_state_e;

    // Entry presented to decode.
    typedef struct packed {
        logic [XLEN-1:0] instr;
        logic [XLEN-1:0] addr;
        logic            misaligned;
    } fetch_entry_t;

    localparam fetch_entry_t EMPTY_ENTRY = '{instr: NOP_INSTR, addr: '0, misaligned: 1'b0};

    function automatic logic is_aligned(input logic [1:0] lsb);
        return lsb == 2'b00;
    endfunction

endpackage

// File: rtl/module_instruction_fetch.sv
// Instruction fetch: one outstanding imem transaction, held word for decode,
// flush with in-flight response discard and misaligned-PC faults.
module module_instruction_fetch
    import module_instruction_fetch_pkg::*;
(
    input  logic            clock,
    input  logic            reset,
    input  logic [XLEN-1:0] pc_addr,
    input  logic            pc_valid,
    output logic            pc_ready,
    input  logic            flush,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_gnt,
    input  logic            imem_rvalid,
    input  logic [XLEN-1:0] imem_rdata,
    output logic            instr_valid,
    output logic [XLEN-1:0] instr,
    output logic [XLEN-1:0] instr_addr,
    input  logic            instr_ready,
    output logic            misaligned
);

    fetch_state_e    state_q, state_d;
    logic            req_q, req_d;
    logic [XLEN-1:0] req_addr_q, req_addr_d;
    logic            valid_q, valid_d;
    fetch_entry_t    entry_q, entry_d;

    logic pc_ready_c;
    logic pc_take_c;
    logic pc_ok_c;

    // PC acceptance: only when nothing is in flight and the held slot frees up.
    always_comb begin
        pc_ready_c = 1'b0;
        unique case (state_q)
            ST_IDLE: pc_ready_c = ~flush;
            ST_HOLD: pc_ready_c = instr_ready & ~flush;
            default: pc_ready_c = 1'b0;
        endcase
    end

    assign pc_take_c = pc_valid & pc_ready_c;
    assign pc_ok_c   = is_aligned(pc_addr[1:0]);

    // Next-state and registered-output logic.
    always_comb begin
        state_d    = state_q;
        req_d      = req_q;
        req_addr_d = req_addr_q;
        valid_d    = valid_q;
        entry_d    = entry_q;

        unique case (state_q)
            ST_IDLE, ST_HOLD: begin
                if (flush) begin
                    state_d = ST_IDLE;
                    valid_d = 1'b0;
                    entry_d = EMPTY_ENTRY;
                end else if (pc_take_c) begin
                    if (pc_ok_c) begin
                        state_d    = ST_REQ;
                        req_d      = 1'b1;
                        req_addr_d = pc_addr;
                        valid_d    = 1'b0;
                        entry_d    = EMPTY_ENTRY;
                    end else begin
                        // Fault entry: no memory access, NOP carried to decode.
                        state_d = ST_HOLD;
                        valid_d = 1'b1;
                        entry_d = '{instr: NOP_INSTR, addr: pc_addr, misaligned: 1'b1};
                    end
                end else if (state_q == ST_HOLD && instr_ready) begin
                    state_d = ST_IDLE;
                    valid_d = 1'b0;
                    entry_d = EMPTY_ENTRY;
                end
            end
            ST_REQ: begin
                if (flush) begin
                    state_d = imem_gnt ? ST_DROP : ST_IDLE;
                    req_d   = 1'b0;
                end else if (imem_gnt) begin
                    state_d = ST_WAIT;
                    req_d   = 1'b0;
                end
            end
            ST_WAIT: begin
                if (flush) begin
                    state_d = imem_rvalid ? ST_IDLE : ST_DROP;
                end else if (imem_rvalid) begin
                    state_d = ST_HOLD;
                    valid_d = 1'b1;
                    entry_d = '{instr: imem_rdata, addr: req_addr_q, misaligned: 1'b0};
                end
            end
            ST_DROP: begin
                if (imem_rvalid) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                req_d   = 1'b0;
                valid_d = 1'b0;
                entry_d = EMPTY_ENTRY;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            req_q      <= 1'b0;
            req_addr_q <= '0;
            valid_q    <= 1'b0;
            entry_q    <= EMPTY_ENTRY;
        end else begin
            state_q    <= state_d;
            req_q      <= req_d;
            req_addr_q <= req_addr_d;
            valid_q    <= valid_d;
            entry_q    <= entry_d;
        end
    end

    assign pc_ready    = pc_ready_c;
    assign imem_req    = req_q;
    assign imem_addr   = req_addr_q;
    assign instr_valid = valid_q;
    assign instr       = entry_q.instr;
    assign instr_addr  = entry_q.addr;
    assign misaligned  = entry_q.misaligned;

endmodule

// File: tb/tb_module_instruction_fetch.sv
// Directed self-checking bench for module_instruction_fetch.
module tb_module_instruction_fetch;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] pc_addr = '0;
    logic        pc_valid = 1'b0;
    logic        pc_ready;
    logic        flush = 1'b0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt = 1'b0;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] instr_addr;
    logic        instr_ready = 1'b0;
    logic        misaligned;

    int n_checks = 0;
    int n_fail   = 0;

    localparam logic [31:0] NOP = 32'h00000013;

    module_instruction_fetch dut (
        .clock       (clock),
        .reset       (reset),
        .pc_addr     (pc_addr),
        .pc_valid    (pc_valid),
        .pc_ready    (pc_ready),
        .flush       (flush),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_gnt    (imem_gnt),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .instr_valid (instr_valid),
        .instr       (instr),
        .instr_addr  (instr_addr),
        .instr_ready (instr_ready),
        .misaligned  (misaligned)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic        granted_prev;
        logic [31:0] gaddr_prev;

        // Reset values
        #1 reset = 1'b1;
        #2;
        check("rst_req",   32'(imem_req), 32'd0);
        check("rst_addr",  imem_addr, 32'd0);
        check("rst_valid", 32'(instr_valid), 32'd0);
        check("rst_instr", instr, NOP);
        check("rst_iaddr", instr_addr, 32'd0);
        check("rst_mis",   32'(misaligned), 32'd0);
        repeat (2) @(posedge clock);
        #1 reset = 1'b0;

        // Single aligned fetch, minimum latency
        pc_addr = 32'h0; pc_valid = 1'b1;
        #1 check("t1_pc_ready", 32'(pc_ready), 32'd1);
        cyc(); pc_valid = 1'b0; imem_gnt = 1'b1;
        #1 check("t1_req", 32'(imem_req), 32'd1);
        check("t1_req_addr", imem_addr, 32'h0);
        cyc(); imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'h00500093;
        #1 check("t1_req_drop", 32'(imem_req), 32'd0);
        check("t1_not_yet", 32'(instr_valid), 32'd0);
        cyc(); imem_rvalid = 1'b0;
        #1 check("t1_valid", 32'(instr_valid), 32'd1);
        check("t1_instr", instr, 32'h00500093);
        check("t1_iaddr", instr_addr, 32'h0);
        check("t1_mis", 32'(misaligned), 32'd0);
        instr_ready = 1'b1;
        cyc(); instr_ready = 1'b0;
        #1 check("t1_consumed", 32'(instr_valid), 32'd0);
        check("t1_nop", instr, NOP);

        // Back-to-back stream 0x0, 0x4, 0x8 with immediate gnt/rvalid
        granted_prev = 1'b0;
        gaddr_prev   = '0;
        for (int c = 0; c <= 9; c++) begin
            if (c > 0) cyc();
            imem_gnt    = imem_req;
            imem_rvalid = granted_prev;
            imem_rdata  = 32'hA0000000 | gaddr_prev;
            pc_valid    = (c % 3 == 0) && (c < 9);
            pc_addr     = 32'(4 * (c / 3));
            instr_ready = 1'b1;
            #1;
            check($sformatf("t2_valid_c%0d", c), 32'(instr_valid), 32'((c % 3 == 0) && (c > 0)));
            check($sformatf("t2_req_c%0d", c), 32'(imem_req), 32'(c % 3 == 1));
            if (c > 0 && c % 3 == 0) begin
                check($sformatf("t2_iaddr_c%0d", c), instr_addr, 32'(4 * (c / 3 - 1)));
                check($sformatf("t2_instr_c%0d", c), instr, 32'hA0000000 | 32'(4 * (c / 3 - 1)));
            end
            if (c % 3 == 0)
                check($sformatf("t2_pc_ready_c%0d", c), 32'(pc_ready), 32'd1);
            granted_prev = imem_gnt;
            gaddr_prev   = imem_addr;
        end
        cyc(); imem_gnt = 1'b0; imem_rvalid = 1'b0; instr_ready = 1'b0; pc_valid = 1'b0;
        #1 check("t2_idle_valid", 32'(instr_valid), 32'd0);
        check("t2_idle_nop", instr, NOP);

        // Misaligned PC: fault entry, no memory access
        cyc(); pc_addr = 32'h6; pc_valid = 1'b1;
        #1 check("t3_pc_ready", 32'(pc_ready), 32'd1);
        cyc(); pc_valid = 1'b0;
        #1 check("t3_no_req", 32'(imem_req), 32'd0);
        check("t3_valid", 32'(instr_valid), 32'd1);
        check("t3_mis", 32'(misaligned), 32'd1);
        check("t3_instr", instr, NOP);
        check("t3_iaddr", instr_addr, 32'h6);
        cyc();
        #1 check("t3_stall_iaddr", instr_addr, 32'h6);
        instr_ready = 1'b1; pc_valid = 1'b1; pc_addr = 32'h2;
        #1 check("t3_hold_pc_ready", 32'(pc_ready), 32'd1);
        cyc(); pc_valid = 1'b0;
        #1 check("t3_b2b_valid", 32'(instr_valid), 32'd1);
        check("t3_b2b_iaddr", instr_addr, 32'h2);
        check("t3_b2b_mis", 32'(misaligned), 32'd1);
        check("t3_b2b_no_req", 32'(imem_req), 32'd0);
        cyc(); instr_ready = 1'b0;
        #1 check("t3_done_valid", 32'(instr_valid), 32'd0);
        check("t3_done_mis", 32'(misaligned), 32'd0);

        // Flush in WAIT, late response discarded, then normal fetch
        cyc(); pc_addr = 32'h10; pc_valid = 1'b1;
        cyc(); pc_valid = 1'b0; imem_gnt = 1'b1;
        #1 check("t4_req", 32'(imem_req), 32'd1);
        check("t4_req_addr", imem_addr, 32'h10);
        cyc(); imem_gnt = 1'b0; flush = 1'b1;
        #1 check("t4_flush_pc_ready", 32'(pc_ready), 32'd0);
        cyc(); flush = 1'b0; pc_valid = 1'b1; pc_addr = 32'h40;
        #1 check("t4_drop_pc_ready", 32'(pc_ready), 32'd0);
        check("t4_drop_valid", 32'(instr_valid), 32'd0);
        check("t4_drop_req", 32'(imem_req), 32'd0);
        cyc(); imem_rvalid = 1'b1; imem_rdata = 32'hDEADBEEF;
        #1 check("t4_drop_rv_pc_ready", 32'(pc_ready), 32'd0);
        cyc(); imem_rvalid = 1'b0;
        #1 check("t4_discard_valid", 32'(instr_valid), 32'd0);
        check("t4_discard_instr", instr, NOP);
        check("t4_idle_pc_ready", 32'(pc_ready), 32'd1);
        cyc(); pc_valid = 1'b0; imem_gnt = 1'b1;
        #1 check("t4_next_req", 32'(imem_req), 32'd1);
        check("t4_next_addr", imem_addr, 32'h40);
        cyc(); imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'h11111111;
        #1 check("t4_wait_valid", 32'(instr_valid), 32'd0);
        cyc(); imem_rvalid = 1'b0;
        #1 check("t4_next_valid", 32'(instr_valid), 32'd1);
        check("t4_next_instr", instr, 32'h11111111);
        check("t4_next_iaddr", instr_addr, 32'h40);
        instr_ready = 1'b1;
        cyc(); instr_ready = 1'b0;
        #1 check("t4_consumed", 32'(instr_valid), 32'd0);

        // Delayed grant and stalled decode: request and held entry stay stable
        cyc(); pc_addr = 32'h20; pc_valid = 1'b1;
        cyc(); pc_addr = 32'h99;
        for (int k = 0; k < 4; k++) begin
            if (k > 0) cyc();
            imem_gnt = (k == 3);
            #1 check($sformatf("t5_req_k%0d", k), 32'(imem_req), 32'd1);
            check($sformatf("t5_addr_k%0d", k), imem_addr, 32'h20);
            check($sformatf("t5_pc_ready_k%0d", k), 32'(pc_ready), 32'd0);
        end
        cyc(); imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'hCAFEF00D; pc_valid = 1'b0;
        #1 check("t5_wait_req", 32'(imem_req), 32'd0);
        cyc(); imem_rvalid = 1'b0; pc_valid = 1'b1; pc_addr = 32'h24;
        for (int k = 0; k < 5; k++) begin
            if (k > 0) cyc();
            #1 check($sformatf("t5_hold_valid_k%0d", k), 32'(instr_valid), 32'd1);
            check($sformatf("t5_hold_instr_k%0d", k), instr, 32'hCAFEF00D);
            check($sformatf("t5_hold_iaddr_k%0d", k), instr_addr, 32'h20);
            check($sformatf("t5_hold_pc_ready_k%0d", k), 32'(pc_ready), 32'd0);
        end
        flush = 1'b1; instr_ready = 1'b1;
        #1 check("t5_flush_pc_ready", 32'(pc_ready), 32'd0);
        cyc(); flush = 1'b0; pc_valid = 1'b0; instr_ready = 1'b0;
        #1 check("t5_flushed_valid", 32'(instr_valid), 32'd0);
        check("t5_flushed_instr", instr, NOP);
        check("t5_flushed_req", 32'(imem_req), 32'd0);

        // Reset during WAIT, then a late response is ignored
        cyc(); pc_addr = 32'h30; pc_valid = 1'b1;
        cyc(); pc_valid = 1'b0; imem_gnt = 1'b1;
        cyc(); imem_gnt = 1'b0;
        #1 check("t6_wait_addr", imem_addr, 32'h30);
        reset = 1'b1;
        #1 check("t6_rst_req", 32'(imem_req), 32'd0);
        check("t6_rst_addr", imem_addr, 32'd0);
        check("t6_rst_valid", 32'(instr_valid), 32'd0);
        check("t6_rst_instr", instr, NOP);
        check("t6_rst_iaddr", instr_addr, 32'd0);
        cyc(); reset = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'hBADBAD00;
        cyc(); imem_rvalid = 1'b0;
        #1 check("t6_late_valid", 32'(instr_valid), 32'd0);
        check("t6_late_instr", instr, NOP);
        check("t6_late_pc_ready", 32'(pc_ready), 32'd1);
        check("t6_late_req", 32'(imem_req), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
